// File: rtl/circle_pos_ctrl_pkg.sv
// Shared constants and types for the OLED circle overlay: panel geometry, default radius,
// home position, direction/FSM encodings and the clamp-limit helpers.
package circle_pos_ctrl_pkg;

    localparam int POS_W      = 7;
    localparam int SCREEN_W   = 96;
    localparam int SCREEN_H   = 64;
    localparam int DEF_RADIUS = 6;

    localparam logic [POS_W-1:0] HOME_X = 7'd48;
    localparam logic [POS_W-1:0] HOME_Y = 7'd32;

    // Bit positions of the buttons inside the top-level press vector.
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTRE = 4;
    localparam int NUM_BTN    = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] x_min;
        logic [POS_W-1:0] x_max;
        logic [POS_W-1:0] y_min;
        logic [POS_W-1:0] y_max;
    } limits_t;

    // Centre range that keeps a circle of the given radius fully on the panel.
    function automatic limits_t make_limits(input int radius);
        limits_t lim;
        lim.x_min = POS_W'(radius);
        lim.x_max = POS_W'(SCREEN_W - 1 - radius);
        lim.y_min = POS_W'(radius);
        lim.y_max = POS_W'(SCREEN_H - 1 - radius);
        return lim;
    endfunction

    function automatic logic at_limit(input dir_t d,
                                      input logic [POS_W-1:0] x,
                                      input logic [POS_W-1:0] y,
                                      input limits_t lim);
        logic hit;
        hit = 1'b0;
        case (d)
            DIR_UP:    hit = (y == lim.y_min);
            DIR_DOWN:  hit = (y == lim.y_max);
            DIR_LEFT:  hit = (x == lim.x_min);
            DIR_RIGHT: hit = (x == lim.x_max);
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw asynchronous pushbutton followed by a rising-edge
// detector; rise is high for one cycle, two clocks after the button goes high.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_d <= 1'b0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
        end
    end

    // Decoded from registers only, so nothing downstream sees the raw pin.
    assign rise = sync_2 & ~sync_2_d;

endmodule

// File: rtl/circle_pos_ctrl.sv
// Button-driven centre position for the circle overlay: accepted presses start continuous
// one-pixel-per-tick motion, clamped to the panel; centre stops and recentres.
module circle_pos_ctrl
    import circle_pos_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 3_333_333,
    parameter int LOCK_CYCLES = 20_000_000,
    parameter int RADIUS      = DEF_RADIUS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_centre,
    output logic [POS_W-1:0] base_x,
    output logic [POS_W-1:0] base_y,
    output logic             moving,
    output logic [1:0]       dir
);

    localparam limits_t LIM = make_limits(RADIUS);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] rise;

    logic [LOCK_W-1:0]  lockout;
    logic [TICK_W-1:0]  tick;
    state_t             state;
    dir_t               dir_q;

    logic               accept;
    logic               sel_centre;
    dir_t               sel_dir;
    logic               sel_blocked;
    logic               step_fire;
    logic [POS_W-1:0]   step_x;
    logic [POS_W-1:0]   step_y;
    logic               step_done;

    assign btn_raw[BTN_UP]     = btn_up;
    assign btn_raw[BTN_DOWN]   = btn_down;
    assign btn_raw[BTN_LEFT]   = btn_left;
    assign btn_raw[BTN_RIGHT]  = btn_right;
    assign btn_raw[BTN_CENTRE] = btn_centre;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .rise  (rise[i])
        );
    end

    // Only the highest-priority edge of a cycle is considered; the rest are lost.
    always_comb begin
        sel_centre = 1'b0;
        sel_dir    = DIR_UP;
        if (rise[BTN_CENTRE]) begin
            sel_centre = 1'b1;
        end else if (rise[BTN_UP]) begin
            sel_dir = DIR_UP;
        end else if (rise[BTN_DOWN]) begin
            sel_dir = DIR_DOWN;
        end else if (rise[BTN_LEFT]) begin
            sel_dir = DIR_LEFT;
        end else begin
            sel_dir = DIR_RIGHT;
        end
    end

    assign accept      = (lockout == '0) && (|rise);
    assign sel_blocked = at_limit(sel_dir, base_x, base_y, LIM);
    assign step_fire   = (state == ST_MOVE) && (tick == TICK_LAST);

    // Limit is checked before the inc/dec, so the 7-bit position can never wrap.
    always_comb begin
        step_x = base_x;
        step_y = base_y;
        if (!at_limit(dir_q, base_x, base_y, LIM)) begin
            case (dir_q)
                DIR_UP:    step_y = base_y - 1'b1;
                DIR_DOWN:  step_y = base_y + 1'b1;
                DIR_LEFT:  step_x = base_x - 1'b1;
                DIR_RIGHT: step_x = base_x + 1'b1;
                default:   step_x = base_x;
            endcase
        end
        step_done = at_limit(dir_q, step_x, step_y, LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockout <= '0;
        end else if (accept) begin
            lockout <= LOCK_LOAD;
        end else if (lockout != '0) begin
            lockout <= lockout - 1'b1;
        end
    end

    // A press consumes its cycle: any step due on that same edge is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            dir_q  <= DIR_UP;
            base_x <= HOME_X;
            base_y <= HOME_Y;
            tick   <= '0;
        end else if (accept) begin
            if (sel_centre) begin
                state  <= ST_IDLE;
                base_x <= HOME_X;
                base_y <= HOME_Y;
                tick   <= '0;
            end else if (!sel_blocked) begin
                state <= ST_MOVE;
                dir_q <= sel_dir;
                tick  <= '0;
            end
        end else if (state == ST_MOVE) begin
            if (step_fire) begin
                tick   <= '0;
                base_x <= step_x;
                base_y <= step_y;
                if (step_done) begin
                    state <= ST_IDLE;
                end
            end else begin
                tick <= tick + 1'b1;
            end
        end else begin
            tick <= '0;
        end
    end

    assign moving = (state == ST_MOVE);
    assign dir    = dir_q;

endmodule

// File: tb/tb_circle_pos_ctrl.sv
// Bench for circle_pos_ctrl with a short tick (10) and lockout (4): a vector table of
// press/wait/expect records plus hand-written overlap and reset sequences.
module tb_circle_pos_ctrl;

    localparam int TICK_DIV    = 10;
    localparam int LOCK_CYCLES = 4;

    localparam logic [1:0] D_UP = 2'd0, D_DN = 2'd1, D_LT = 2'd2, D_RT = 2'd3;
    localparam logic [4:0] B_NONE = 5'b00000, B_UP = 5'b00001, B_DN = 5'b00010,
                           B_LT = 5'b00100, B_RT = 5'b01000, B_CT = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_centre = 1'b0;
    logic [6:0] base_x, base_y;
    logic       moving;
    logic [1:0] dir;

    circle_pos_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_centre (btn_centre),
        .base_x     (base_x),
        .base_y     (base_y),
        .moving     (moving),
        .dir        (dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] btn;
        int         wait_cyc;
        logic [6:0] ex;
        logic [6:0] ey;
        logic       em;
        logic [1:0] ed;
        string      name;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic add_vec(input logic [4:0] b, input int w, input logic [6:0] x, input logic [6:0] y,
                           input logic m, input logic [1:0] d, input string nm);
        vec_t v;
        v.btn = b; v.wait_cyc = w; v.ex = x; v.ey = y; v.em = m; v.ed = d; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive_btn(input logic [4:0] b);
        btn_up     = b[0];
        btn_down   = b[1];
        btn_left   = b[2];
        btn_right  = b[3];
        btn_centre = b[4];
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse; returns just after the edge on which the controller acts on it.
    task automatic press(input logic [4:0] b);
        @(posedge clk); #1 drive_btn(b);
        @(posedge clk); #1 drive_btn(B_NONE);
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string nm, input logic [6:0] x, input logic [6:0] y,
                              input logic m, input logic [1:0] d);
        exp_q.push_back({x, y, m, d});
        name_q.push_back(nm);
    endtask

    task automatic compare_out();
        logic [16:0] want;
        logic [16:0] got;
        string       nm;
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {base_x, base_y, moving, dir};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d moving=%0d dir=%0d, want x=%0d y=%0d moving=%0d dir=%0d",
                     nm, got[16:10], got[9:3], got[2], got[1:0],
                     want[16:10], want[9:3], want[2], want[1:0]);
        end
    endtask

    task automatic check(input string nm, input logic [6:0] x, input logic [6:0] y,
                         input logic m, input logic [1:0] d);
        expect_out(nm, x, y, m, d);
        compare_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        add_vec(B_RT,      0, 48, 32, 1, D_RT, "right_acc");
        add_vec(B_NONE,    9, 48, 32, 1, D_RT, "right_pre_step");
        add_vec(B_NONE,    1, 49, 32, 1, D_RT, "right_step1");
        add_vec(B_NONE,   10, 50, 32, 1, D_RT, "right_step2");
        add_vec(B_NONE,  389, 88, 32, 1, D_RT, "right_near_edge");
        add_vec(B_NONE,    1, 89, 32, 0, D_RT, "right_edge");
        add_vec(B_NONE,   50, 89, 32, 0, D_RT, "right_hold");
        add_vec(B_RT,      0, 89, 32, 0, D_RT, "right_at_limit");
        add_vec(B_LT,      0, 89, 32, 1, D_LT, "left_after_lockout");
        add_vec(B_NONE,   10, 88, 32, 1, D_LT, "left_step1");
        add_vec(B_CT,      0, 48, 32, 0, D_LT, "centre_from_left");
        add_vec(B_UP,      0, 48, 32, 1, D_UP, "up_acc");
        add_vec(B_NONE,   26, 48, 30, 1, D_UP, "up_two_steps");
        add_vec(B_DN,      0, 48, 30, 1, D_DN, "press_beats_step");
        add_vec(B_NONE,    9, 48, 30, 1, D_DN, "reverse_pre_step");
        add_vec(B_NONE,    1, 48, 31, 1, D_DN, "reverse_step1");
        add_vec(B_UP,      0, 48, 31, 1, D_UP, "up_again");
        add_vec(B_NONE,  110, 48, 20, 1, D_UP, "up_at_20");
        add_vec(B_CT,      0, 48, 32, 0, D_UP, "centre_mid_move");
        add_vec(B_NONE,   30, 48, 32, 0, D_UP, "centre_no_steps");
        add_vec(B_UP,      0, 48, 32, 1, D_UP, "up_restart");
        add_vec(B_NONE,  259, 48,  7, 1, D_UP, "up_near_edge");
        add_vec(B_NONE,    1, 48,  6, 0, D_UP, "up_edge");
        add_vec(B_UP,      0, 48,  6, 0, D_UP, "up_at_limit");
        add_vec(B_CT|B_RT, 0, 48, 32, 0, D_UP, "centre_beats_right");
        add_vec(B_LT,      0, 48, 32, 1, D_LT, "left_acc");
        add_vec(B_NONE,  420,  6, 32, 0, D_LT, "left_edge");
        add_vec(B_LT,      0,  6, 32, 0, D_LT, "left_at_limit");
        add_vec(B_DN,      0,  6, 32, 1, D_DN, "down_acc");
        add_vec(B_NONE,  249,  6, 56, 1, D_DN, "down_near_edge");
        add_vec(B_NONE,    1,  6, 57, 0, D_DN, "down_edge");
        add_vec(B_DN,      0,  6, 57, 0, D_DN, "down_at_limit");
        add_vec(B_CT,      0, 48, 32, 0, D_DN, "centre_home");

        // Reset and idle stability
        drive_btn(B_NONE);
        rst_n = 1'b0;
        wait_cyc(3);
        check("reset_hold", 48, 32, 0, D_UP);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_cyc(1);
            check("idle_stable", 48, 32, 0, D_UP);
        end

        foreach (vecs[i]) begin
            if (vecs[i].btn != B_NONE) press(vecs[i].btn);
            wait_cyc(vecs[i].wait_cyc);
            check(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].em, vecs[i].ed);
        end

        // Up and left rise together; down follows two cycles later inside the lockout.
        @(posedge clk); #1 drive_btn(B_UP | B_LT);
        @(posedge clk); #1 drive_btn(B_NONE);
        @(posedge clk); #1 drive_btn(B_DN);
        @(posedge clk); #1 drive_btn(B_NONE);
        check("up_beats_left", 48, 32, 1, D_UP);
        wait_cyc(3);
        check("down_dropped", 48, 32, 1, D_UP);
        press(B_DN);
        check("down_after_lockout", 48, 32, 1, D_DN);
        wait_cyc(9);
        check("tick_restarted", 48, 32, 1, D_DN);
        wait_cyc(1);
        check("down_step1", 48, 33, 1, D_DN);

        // Reset pulse mid-move
        wait_cyc(5);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("async_reset", 48, 32, 0, D_UP);
        @(negedge clk) rst_n = 1'b1;
        wait_cyc(10);
        check("post_reset_idle", 48, 32, 0, D_UP);
        wait_cyc(40);
        check("post_reset_no_step", 48, 32, 0, D_UP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
